// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// default memory-map placement and the word-index width helper.
package dmem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    // Number of index bits needed to address 'depth' words (minimum 1).
    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while (w < 31 && (32'd1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Single-port synchronous word RAM with one write enable and a registered
// read port. Only the read register is reset; the storage never is.
module dmem_array
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read register only loads on a read strobe, otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Registered read data with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: edge-detects the processor's level request,
// captures it, waits a fixed latency, then performs (or rejects) the
// access and pulses mem_ready for one cycle.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int unsigned IDX_W      = idx_width(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
    // 33-bit limit so a window ending at 2^32 does not wrap to zero.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    logic [1:0]  state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        req_prev_q, req_prev_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        rd_q,       rd_d;
    logic        wr_q,       wr_d;
    logic        ready_q,    ready_d;
    logic        err_q,      err_d;

    logic             req;
    logic             reject;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             ram_we;
    logic             ram_re;

    assign req      = MemRead | MemWrite;
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = IDX_W'(offset >> 2);

    // Reject decision is made on captured values only.
    always_comb begin
        reject = (addr_q[1:0] != 2'b00)
               | (addr_q < BASE_ADDR)
               | ({1'b0, addr_q} >= ADDR_LIMIT)
               | (rd_q & wr_q);
    end

    // Next-state, capture, counter and completion strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_prev_d = req;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !req_prev_q) begin
                    addr_d  = dAddress;
                    wdata_d = dWriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    err_d   = reject;
                    ram_we  = wr_q & ~reject & ~rst;
                    ram_re  = rd_q & ~reject & ~rst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_prev_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_prev_q <= req_prev_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (word_idx),
        .wdata (wdata_q),
        .rdata (dReadData)
    );

    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with default map and LATENCY=2.
module tb_dmem_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        mem_ready;
    logic        mem_err;

    int tests;
    int fails;

    dmem_ctrl #(
        .BASE_ADDR   (32'h1001_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request from idle, wait (bounded) for mem_ready, then drop it.
    // lat = edges from request assertion to the edge that raised mem_ready, -1 on timeout.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic err);
        int n;
        MemRead    = rd;
        MemWrite   = wr;
        dAddress   = a;
        dWriteData = d;
        lat = -1;
        err = 1'b0;
        n   = 0;
        while (lat < 0 && n < 20) begin
            step();
            n = n + 1;
            if (mem_ready) begin
                lat = n;
                err = mem_err;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", mem_err); end
        tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", dReadData); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_hold();
        int   pulses;
        int   lat;
        logic err;
        pulses     = 0;
        MemWrite   = 1'b1;
        dAddress   = 32'h1001_0004;
        dWriteData = 32'hDEAD_BEEF;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (mem_ready) pulses++;
            tests++; if (mem_ready !== (i == LAT + 1)) begin fails++; $display("FAIL hold_ready_e%0d: got %b expected %b", i, mem_ready, (i == LAT + 1)); end
            if (i == LAT + 1) begin
                tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL hold_err: got %b expected 0", mem_err); end
            end
            if (i == 5) MemWrite = 1'b0;
        end
        step();
        tests++; if (pulses !== 1) begin fails++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
        access(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err);
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL rd_lat: got %0d expected %0d", lat, LAT + 1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err: got %b expected 0", err); end
        tests++; if (dReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", dReadData); end
    endtask

    task automatic test_misaligned();
        int   lat;
        logic err;
        access(1'b0, 1'b1, 32'h1001_0000, 32'h1111_1111, lat, err);
        access(1'b0, 1'b1, 32'h1001_0FFC, 32'h2222_2222, lat, err);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL top_word_err: got %b expected 0", err); end
        access(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err);
        access(1'b1, 1'b0, 32'h1001_0002, 32'h0, lat, err);
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL mis_rd_lat: got %0d expected %0d", lat, LAT + 1); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_rd_err: got %b expected 1", err); end
        tests++; if (dReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mis_rd_data: got %h expected deadbeef", dReadData); end
        access(1'b0, 1'b1, 32'h1001_0006, 32'h0BAD_0BAD, lat, err);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_wr_err: got %b expected 1", err); end
        access(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, err);
        tests++; if (dReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mis_wr_nowrite: got %h expected deadbeef", dReadData); end
    endtask

    task automatic test_range();
        int   lat;
        logic err;
        access(1'b0, 1'b1, 32'h1001_1000, 32'hBAD0_BAD0, lat, err);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL hi_wr_err: got %b expected 1", err); end
        access(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, lat, err);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL lo_rd_err: got %b expected 1", err); end
        tests++; if (dReadData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lo_rd_data: got %h expected deadbeef", dReadData); end
        access(1'b0, 1'b1, 32'h0001_0000, 32'hBAD1_BAD1, lat, err);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL wrap_wr_err: got %b expected 1", err); end
        access(1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, err);
        tests++; if (dReadData !== 32'h1111_1111) begin fails++; $display("FAIL word0_kept: got %h expected 11111111", dReadData); end
        access(1'b1, 1'b0, 32'h1001_0FFC, 32'h0, lat, err);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL word1023_err: got %b expected 0", err); end
        tests++; if (dReadData !== 32'h2222_2222) begin fails++; $display("FAIL word1023_kept: got %h expected 22222222", dReadData); end
    endtask

    task automatic test_both();
        int   lat;
        logic err;
        access(1'b0, 1'b1, 32'h1001_0008, 32'h4444_4444, lat, err);
        access(1'b1, 1'b1, 32'h1001_0008, 32'h3333_3333, lat, err);
        tests++; if (lat !== LAT + 1) begin fails++; $display("FAIL both_lat: got %0d expected %0d", lat, LAT + 1); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL both_err: got %b expected 1", err); end
        access(1'b1, 1'b0, 32'h1001_0008, 32'h0, lat, err);
        tests++; if (dReadData !== 32'h4444_4444) begin fails++; $display("FAIL both_nowrite: got %h expected 44444444", dReadData); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic err;
        access(1'b0, 1'b1, 32'h1001_0014, 32'h5555_5555, lat, err);
        MemWrite   = 1'b1;
        dAddress   = 32'h1001_0014;
        dWriteData = 32'h6666_6666;
        step();
        rst = 1'b1;
        step();
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready: got %b expected 0", mem_ready); end
        tests++; if (dReadData !== 32'h0) begin fails++; $display("FAIL rstmid_rdata: got %h expected 00000000", dReadData); end
        rst        = 1'b0;
        dAddress   = 32'h1001_0018;
        dWriteData = 32'h7777_7777;
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            tests++; if (mem_ready !== (i == LAT + 1)) begin fails++; $display("FAIL rstmid_ready_e%0d: got %b expected %b", i, mem_ready, (i == LAT + 1)); end
        end
        tests++; if (mem_err !== 1'b0) begin fails++; $display("FAIL rstmid_err: got %b expected 0", mem_err); end
        MemWrite = 1'b0;
        step();
        access(1'b1, 1'b0, 32'h1001_0014, 32'h0, lat, err);
        tests++; if (dReadData !== 32'h5555_5555) begin fails++; $display("FAIL rstmid_kept: got %h expected 55555555", dReadData); end
        access(1'b1, 1'b0, 32'h1001_0018, 32'h0, lat, err);
        tests++; if (dReadData !== 32'h7777_7777) begin fails++; $display("FAIL rstmid_fresh: got %h expected 77777777", dReadData); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic err;
        int   pulses;
        logic exp_rdy;
        access(1'b0, 1'b1, 32'h1001_001C, 32'hA7A7_A7A7, lat, err);
        access(1'b0, 1'b1, 32'h1001_0020, 32'hA8A8_A8A8, lat, err);
        pulses   = 0;
        MemRead  = 1'b1;
        dAddress = 32'h1001_001C;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (mem_ready) pulses++;
            exp_rdy = (i == LAT + 1) || (i == 2 * LAT + 3);
            tests++; if (mem_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready_e%0d: got %b expected %b", i, mem_ready, exp_rdy); end
            if (i == 1) dAddress = 32'h1001_0020;
            if (i == LAT + 1) begin
                tests++; if (dReadData !== 32'hA7A7_A7A7) begin fails++; $display("FAIL b2b_first_data: got %h expected a7a7a7a7", dReadData); end
                MemRead = 1'b0;
            end
            if (i == LAT + 2) MemRead = 1'b1;
            if (i == 2 * LAT + 3) begin
                tests++; if (dReadData !== 32'hA8A8_A8A8) begin fails++; $display("FAIL b2b_second_data: got %h expected a8a8a8a8", dReadData); end
                MemRead = 1'b0;
            end
        end
        tests++; if (pulses !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        dAddress   = '0;
        dWriteData = '0;
        test_reset();
        test_write_hold();
        test_misaligned();
        test_range();
        test_both();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
